cond_unit_it: RTL

//  Execute-stage condition unit with its own NZCV flags register, per-group flag write enables,

---
 rtl/cond_pkg.sv | 35 +++
 rtl/cond_eval_nzcv.sv | 41 ++++
 rtl/cond_unit_it.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/cond_pkg.sv
// Shared definitions for the execute-stage condition unit: ARM condition
// codes, NZCV bit positions and the IT sequencer state encoding.
package cond_pkg;

   // ARM condition field encodings
   localparam logic [3:0] COND_EQ = 4'h0;
   localparam logic [3:0] COND_NE = 4'h1;
   localparam logic [3:0] COND_CS = 4'h2;
   localparam logic [3:0] COND_CC = 4'h3;
   localparam logic [3:0] COND_MI = 4'h4;
   localparam logic [3:0] COND_PL = 4'h5;
   localparam logic [3:0] COND_VS = 4'h6;
   localparam logic [3:0] COND_VC = 4'h7;
   localparam logic [3:0] COND_HI = 4'h8;
   localparam logic [3:0] COND_LS = 4'h9;
   localparam logic [3:0] COND_GE = 4'hA;
   localparam logic [3:0] COND_LT = 4'hB;
   localparam logic [3:0] COND_GT = 4'hC;
   localparam logic [3:0] COND_LE = 4'hD;
   localparam logic [3:0] COND_AL = 4'hE;
   localparam logic [3:0] COND_NV = 4'hF;

   // Bit positions inside the NZCV nibble
   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   // IT sequencer states
   typedef enum logic {
      IT_IDLE   = 1'b0,
      IT_ACTIVE = 1'b1
   } it_state_e;

endpackage

// File: rtl/cond_eval_nzcv.sv
// Combinational ARM condition check: 4-bit condition field against NZCV.
module cond_eval_nzcv
   import cond_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] flags,
   output logic       pass
);

   logic n, z, c, v;

   assign n = flags[FLAG_N];
   assign z = flags[FLAG_Z];
   assign c = flags[FLAG_C];
   assign v = flags[FLAG_V];

   // Standard ARM condition table; AL and the 1111 encoding both always pass
   always_comb begin
      pass = 1'b1;
      case (cond)
         COND_EQ: pass = z;
         COND_NE: pass = ~z;
         COND_CS: pass = c;
         COND_CC: pass = ~c;
         COND_MI: pass = n;
         COND_PL: pass = ~n;
         COND_VS: pass = v;
         COND_VC: pass = ~v;
         COND_HI: pass = c & ~z;
         COND_LS: pass = ~c | z;
         COND_GE: pass = (n == v);
         COND_LT: pass = (n != v);
         COND_GT: pass = ~z & (n == v);
         COND_LE: pass = z | (n != v);
         COND_AL: pass = 1'b1;
         COND_NV: pass = 1'b1;
         default: pass = 1'b1;
      endcase
   end

endmodule

// File: rtl/cond_unit_it.sv
// Execute-stage condition unit: architectural NZCV register with per-group
// write enables, condition gating of PC/register/memory writes, and an IT
// block sequencer that supplies the condition for predicated followers.
module cond_unit_it
   import cond_pkg::*;
#(
   parameter int NUM_FLAG_GROUPS = 2,
   parameter int IT_DEPTH        = 4,
   parameter int ENABLE_IT       = 1,
   localparam int LW             = $clog2(IT_DEPTH + 1)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       Valid,
   input  logic                       Stall,
   input  logic                       Flush,
   input  logic [3:0]                 Cond,
   input  logic [3:0]                 ALUFlags,
   input  logic [NUM_FLAG_GROUPS-1:0] FlagW,
   input  logic                       PCS,
   input  logic                       RegW,
   input  logic                       MemW,
   input  logic                       Branch,
   input  logic                       ITStart,
   input  logic [3:0]                 ITCond,
   input  logic [LW-1:0]              ITLen,
   input  logic [IT_DEPTH-1:0]        ITElse,
   output logic [3:0]                 Flags,
   output logic                       CondEx,
   output logic                       PCSrc,
   output logic                       RegWrite,
   output logic                       MemWrite,
   output logic                       ITActive,
   output logic [LW-1:0]              ITRemain
);

   localparam int IW = (IT_DEPTH > 1) ? $clog2(IT_DEPTH) : 1;
   localparam int GW = 4 / NUM_FLAG_GROUPS;   // flag bits per write group

   it_state_e            state_q,  state_d;
   logic [LW-1:0]        remain_q, remain_d;
   logic [IW-1:0]        idx_q,    idx_d;
   logic [3:0]           itcond_q, itcond_d;
   logic [IT_DEPTH-1:0]  itelse_q, itelse_d;
   logic [3:0]           flags_q,  flags_d;

   logic                 fire;
   logic                 it_start;
   logic [3:0]           eff_cond;
   logic                 cond_pass;
   logic [LW-1:0]        len_clamped;

   // Only a real, unstalled, unsquashed instruction may change state or write
   assign fire     = Valid & ~Stall & ~Flush & ~reset;
   assign it_start = ITStart & (ENABLE_IT != 0);

   // Followers inside an active block use the latched IT condition, possibly inverted;
   // an opener (even one restarting a block) is evaluated on its own condition field
   always_comb begin
      eff_cond = Cond;
      if (state_q == IT_ACTIVE && !it_start)
         eff_cond = {itcond_q[3:1], itcond_q[0] ^ itelse_q[idx_q]};
   end

   cond_eval_nzcv u_eval (
      .cond  (eff_cond),
      .flags (flags_q),
      .pass  (cond_pass)
   );

   // The IT opener itself always executes
   assign CondEx   = cond_pass | it_start;
   assign PCSrc    = fire & CondEx & (PCS | Branch);
   assign RegWrite = fire & CondEx & RegW;
   assign MemWrite = fire & CondEx & MemW;
   assign Flags    = flags_q;

   // Per-group flag write: each group independently takes ALUFlags when enabled
   always_comb begin
      flags_d = flags_q;
      if (fire && CondEx) begin
         for (int b = 0; b < 4; b++) begin
            if (FlagW[b / GW])
               flags_d[b] = ALUFlags[b];
         end
      end
   end

   // Over-long IT blocks are trimmed to the sequencer depth
   always_comb begin
      len_clamped = ITLen;
      if (ITLen > LW'(IT_DEPTH))
         len_clamped = LW'(IT_DEPTH);
   end

   // IT next state: flush clears, opener (re)loads, each fired follower consumes a slot,
   // a taken branch terminates the block early
   always_comb begin
      state_d  = state_q;
      remain_d = remain_q;
      idx_d    = idx_q;
      itcond_d = itcond_q;
      itelse_d = itelse_q;
      if (ENABLE_IT == 0) begin
         state_d  = IT_IDLE;
         remain_d = '0;
         idx_d    = '0;
      end else if (Flush) begin
         state_d  = IT_IDLE;
         remain_d = '0;
         idx_d    = '0;
      end else if (fire) begin
         if (it_start) begin
            if (ITLen != '0) begin
               state_d  = IT_ACTIVE;
               remain_d = len_clamped;
               idx_d    = '0;
               itcond_d = ITCond;
               itelse_d = ITElse;
            end
         end else if (state_q == IT_ACTIVE) begin
            if (PCSrc || remain_q <= LW'(1)) begin
               state_d  = IT_IDLE;
               remain_d = '0;
               idx_d    = '0;
            end else begin
               remain_d = remain_q - LW'(1);
               idx_d    = idx_q + IW'(1);
            end
         end
      end
   end

   // State register: synchronous reset returns to IDLE with cleared flags
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IT_IDLE;
         remain_q <= '0;
         idx_q    <= '0;
         itcond_q <= '0;
         itelse_q <= '0;
         flags_q  <= '0;
      end else begin
         state_q  <= state_d;
         remain_q <= remain_d;
         idx_q    <= idx_d;
         itcond_q <= itcond_d;
         itelse_q <= itelse_d;
         flags_q  <= flags_d;
      end
   end

   // IT status outputs
   always_comb begin
      ITActive = (state_q == IT_ACTIVE);
      ITRemain = remain_q;
   end

endmodule
